laser_score: RTL and testbench

Downstream scoring stage for the LASER circle-placement engine. It captures the same 40-point stream that LASER consumes, then waits for LASER's DONE pulse and latches the two chosen centres. It re-evaluates every point against both radius-4 circles and reports per-circle and union coverage counts over a valid/ready handshake. The result feeds the top-level result checker/logger and gives an independent measure of LASER's answer quality.

---
 rtl/laser_pkg.sv | 17 +
 rtl/laser_incircle.sv | 28 ++
 rtl/laser_score.sv | 174 +++++++++++++++++
 tb/tb_laser_score.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// Shared constants and types for the LASER circle-placement block family.
package laser_pkg;

  localparam int N_PTS_DEF     = 40;
  localparam int RADIUS_SQ_DEF = 16;
  localparam int COORD_W       = 4;
  localparam int SCORE_W       = 6;
  localparam int IDX_W         = 6;

  typedef enum logic [1:0] {
    LOAD,
    WAIT,
    EVAL,
    RESP
  } state_t;

endpackage

// File: rtl/laser_incircle.sv
// Combinational point-in-circle test: hit when dx^2 + dy^2 <= RADIUS_SQ.
// The sum is kept one bit wider than the squares so it never wraps.
module laser_incircle
  import laser_pkg::*;
#(
  parameter int RADIUS_SQ = RADIUS_SQ_DEF
) (
  input  logic [COORD_W-1:0] cx_i,
  input  logic [COORD_W-1:0] cy_i,
  input  logic [COORD_W-1:0] px_i,
  input  logic [COORD_W-1:0] py_i,
  output logic               hit_o
);

  logic [COORD_W-1:0]   dx;
  logic [COORD_W-1:0]   dy;
  logic [2*COORD_W-1:0] dx_sq;
  logic [2*COORD_W-1:0] dy_sq;
  logic [2*COORD_W:0]   dist_sq;

  assign dx      = (px_i >= cx_i) ? (px_i - cx_i) : (cx_i - px_i);
  assign dy      = (py_i >= cy_i) ? (py_i - cy_i) : (cy_i - py_i);
  assign dx_sq   = (2*COORD_W)'(dx) * (2*COORD_W)'(dx);
  assign dy_sq   = (2*COORD_W)'(dy) * (2*COORD_W)'(dy);
  assign dist_sq = {1'b0, dx_sq} + {1'b0, dy_sq};
  assign hit_o   = (32'(dist_sq) <= 32'(RADIUS_SQ));

endmodule

// File: rtl/laser_score.sv
// Scoring stage for LASER: buffers a point pattern, latches the two chosen
// centres on DONE, counts per-circle and union coverage, returns via valid/ready.
module laser_score
  import laser_pkg::*;
#(
  parameter int N_PTS     = N_PTS_DEF,
  parameter int RADIUS_SQ = RADIUS_SQ_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               PT_VALID,
  input  logic [COORD_W-1:0] X,
  input  logic [COORD_W-1:0] Y,
  input  logic [COORD_W-1:0] C1X,
  input  logic [COORD_W-1:0] C1Y,
  input  logic [COORD_W-1:0] C2X,
  input  logic [COORD_W-1:0] C2Y,
  input  logic               DONE,
  output logic               SCORE_VALID,
  input  logic               SCORE_READY,
  output logic [SCORE_W-1:0] SCORE,
  output logic [SCORE_W-1:0] C1_CNT,
  output logic [SCORE_W-1:0] C2_CNT
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PTS - 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [COORD_W-1:0]   c1x_q, c1x_d, c1y_q, c1y_d;
  logic [COORD_W-1:0]   c2x_q, c2x_d, c2y_q, c2y_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   c1_cnt_q, c1_cnt_d;
  logic [SCORE_W-1:0]   c2_cnt_q, c2_cnt_d;
  logic                 valid_q, valid_d;
  logic                 eval_vld_q, eval_vld_d;
  logic                 last_q, last_d;
  logic [2*COORD_W-1:0] pt_q;
  logic                 hit1, hit2;
  logic                 idx_last;

  logic [2*COORD_W-1:0] pt_buf [N_PTS];

  // Point buffer has no reset; reads are registered so evaluation lags idx by one cycle.
  always_ff @(posedge CLK) begin
    if (state_q == LOAD && PT_VALID) begin
      pt_buf[idx_q] <= {X, Y};
    end
    pt_q <= pt_buf[idx_q];
  end

  laser_incircle #(.RADIUS_SQ(RADIUS_SQ)) u_in_c1 (
    .cx_i (c1x_q),
    .cy_i (c1y_q),
    .px_i (pt_q[2*COORD_W-1:COORD_W]),
    .py_i (pt_q[COORD_W-1:0]),
    .hit_o(hit1)
  );

  laser_incircle #(.RADIUS_SQ(RADIUS_SQ)) u_in_c2 (
    .cx_i (c2x_q),
    .cy_i (c2y_q),
    .px_i (pt_q[2*COORD_W-1:COORD_W]),
    .py_i (pt_q[COORD_W-1:0]),
    .hit_o(hit2)
  );

  assign idx_last = (idx_q == IDX_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= LOAD;
      idx_q      <= '0;
      c1x_q      <= '0;
      c1y_q      <= '0;
      c2x_q      <= '0;
      c2y_q      <= '0;
      score_q    <= '0;
      c1_cnt_q   <= '0;
      c2_cnt_q   <= '0;
      valid_q    <= 1'b0;
      eval_vld_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      c1x_q      <= c1x_d;
      c1y_q      <= c1y_d;
      c2x_q      <= c2x_d;
      c2y_q      <= c2y_d;
      score_q    <= score_d;
      c1_cnt_q   <= c1_cnt_d;
      c2_cnt_q   <= c2_cnt_d;
      valid_q    <= valid_d;
      eval_vld_q <= eval_vld_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    c1x_d      = c1x_q;
    c1y_d      = c1y_q;
    c2x_d      = c2x_q;
    c2y_d      = c2y_q;
    score_d    = score_q;
    c1_cnt_d   = c1_cnt_q;
    c2_cnt_d   = c2_cnt_q;
    valid_d    = valid_q;
    eval_vld_d = 1'b0;
    last_d     = 1'b0;

    // Accumulate the point fetched on the previous cycle.
    if (eval_vld_q) begin
      c1_cnt_d = c1_cnt_q + SCORE_W'(hit1);
      c2_cnt_d = c2_cnt_q + SCORE_W'(hit2);
      score_d  = score_q + SCORE_W'(hit1 | hit2);
    end
    if (last_q) begin
      valid_d = 1'b1;
    end

    unique case (state_q)
      LOAD: begin
        if (PT_VALID) begin
          if (idx_last) begin
            idx_d   = '0;
            state_d = WAIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      WAIT: begin
        if (DONE) begin
          c1x_d    = C1X;
          c1y_d    = C1Y;
          c2x_d    = C2X;
          c2y_d    = C2Y;
          score_d  = '0;
          c1_cnt_d = '0;
          c2_cnt_d = '0;
          idx_d    = '0;
          state_d  = EVAL;
        end
      end
      EVAL: begin
        eval_vld_d = 1'b1;
        if (idx_last) begin
          idx_d   = '0;
          last_d  = 1'b1;
          state_d = RESP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RESP: begin
        if (valid_q && SCORE_READY) begin
          valid_d = 1'b0;
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  assign SCORE_VALID = valid_q;
  assign SCORE       = score_q;
  assign C1_CNT      = c1_cnt_q;
  assign C2_CNT      = c2_cnt_q;

endmodule

// File: tb/tb_laser_score.sv
// Scenario bench for laser_score: expected results are queued when DONE is
// driven and popped when the DUT presents SCORE_VALID.
module tb_laser_score;

  localparam int N = 40;

  typedef struct packed {
    logic [5:0] score;
    logic [5:0] c1;
    logic [5:0] c2;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pt_valid;
  logic [3:0] x, y, c1x, c1y, c2x, c2y;
  logic       done;
  logic       score_valid;
  logic       score_ready;
  logic [5:0] score, c1_cnt, c2_cnt;

  int   px [N];
  int   py [N];
  res_t exp_q [$];
  int   total = 0;
  int   bad = 0;

  laser_score dut (
    .CLK        (clk),
    .RST        (rst_n),
    .PT_VALID   (pt_valid),
    .X          (x),
    .Y          (y),
    .C1X        (c1x),
    .C1Y        (c1y),
    .C2X        (c2x),
    .C2Y        (c2y),
    .DONE       (done),
    .SCORE_VALID(score_valid),
    .SCORE_READY(score_ready),
    .SCORE      (score),
    .C1_CNT     (c1_cnt),
    .C2_CNT     (c2_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t model(int ax, int ay, int bx, int by);
    res_t r;
    int s = 0, a = 0, b = 0;
    for (int i = 0; i < N; i++) begin
      bit h1, h2;
      h1 = ((px[i]-ax)*(px[i]-ax) + (py[i]-ay)*(py[i]-ay)) <= 16;
      h2 = ((px[i]-bx)*(px[i]-bx) + (py[i]-by)*(py[i]-by)) <= 16;
      a += int'(h1);
      b += int'(h2);
      s += int'(h1 | h2);
    end
    r.score = 6'(s);
    r.c1    = 6'(a);
    r.c2    = 6'(b);
    return r;
  endfunction

  // Drives the buffered pattern; at index done_at, DONE is pulsed with the current centres.
  task automatic load_points(input int done_at);
    for (int i = 0; i < N; i++) begin
      pt_valid = 1'b1;
      x = 4'(px[i]);
      y = 4'(py[i]);
      done = (i == done_at);
      tick();
    end
    pt_valid = 1'b0;
    done = 1'b0;
  endtask

  task automatic send_done(input int ax, input int ay, input int bx, input int by,
                           input bit push, input res_t e);
    c1x = 4'(ax); c1y = 4'(ay); c2x = 4'(bx); c2y = 4'(by);
    done = 1'b1;
    if (push) exp_q.push_back(e);
    tick();
    done = 1'b0;
  endtask

  task automatic get_result(input int max_cyc, output bit seen, output int cyc, output res_t r);
    cyc = 0;
    while (score_valid !== 1'b1 && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    seen = (score_valid === 1'b1);
    r = {score, c1_cnt, c2_cnt};
  endtask

  task automatic accept();
    score_ready = 1'b1;
    tick();
    score_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    score_ready = 1'b1;
    repeat (3) tick();
    total++;
    if ({score_valid, score, c1_cnt, c2_cnt} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%0b score=%0d c1=%0d c2=%0d want all 0",
               score_valid, score, c1_cnt, c2_cnt);
    end
    rst_n = 1'b1;
    tick();
    score_ready = 1'b0;
  endtask

  task automatic test_same_centre();
    bit seen; int cyc; res_t r, e;
    for (int i = 0; i < N; i++) begin px[i] = 8; py[i] = 8; end
    load_points(-1);
    send_done(8, 8, 8, 8, 1'b1, {6'd40, 6'd40, 6'd40});
    get_result(100, seen, cyc, r);
    e = exp_q.pop_front();
    total++;
    if (!seen || cyc != 41) begin
      bad++;
      $display("FAIL same_centre_latency: got valid=%0b after %0d cycles want 41", seen, cyc);
    end
    total++;
    if (r !== e) begin
      bad++;
      $display("FAIL same_centre: got score=%0d c1=%0d c2=%0d want %0d/%0d/%0d",
               r.score, r.c1, r.c2, e.score, e.c1, e.c2);
    end
    $display("txn same_centre score=%0d c1=%0d c2=%0d latency=%0d", r.score, r.c1, r.c2, cyc);
    accept();
    total++;
    if (score_valid !== 1'b0) begin
      bad++;
      $display("FAIL same_centre_valid_drop: got valid=%0b want 0", score_valid);
    end
  endtask

  task automatic test_two_clusters();
    bit seen; int cyc; res_t r, e;
    for (int i = 0; i < N; i++) begin
      px[i] = (i % 2 == 0) ? 2 : 13;
      py[i] = px[i];
    end
    load_points(-1);
    send_done(2, 2, 13, 13, 1'b1, {6'd40, 6'd20, 6'd20});
    get_result(100, seen, cyc, r);
    e = exp_q.pop_front();
    total++;
    if (!seen || r !== e) begin
      bad++;
      $display("FAIL two_clusters: valid=%0b got score=%0d c1=%0d c2=%0d want %0d/%0d/%0d",
               seen, r.score, r.c1, r.c2, e.score, e.c1, e.c2);
    end
    $display("txn two_clusters score=%0d c1=%0d c2=%0d", r.score, r.c1, r.c2);
    accept();
  endtask

  task automatic test_boundary();
    bit seen; int cyc; res_t r, e;
    int bx [4] = '{4, 8, 11, 5};
    int by [4] = '{8, 12, 11, 5};
    for (int i = 0; i < N; i++) begin px[i] = bx[i % 4]; py[i] = by[i % 4]; end
    load_points(-1);
    send_done(8, 8, 0, 15, 1'b1, {6'd20, 6'd20, 6'd0});
    get_result(100, seen, cyc, r);
    e = exp_q.pop_front();
    total++;
    if (!seen || r !== e) begin
      bad++;
      $display("FAIL boundary: valid=%0b got score=%0d c1=%0d c2=%0d want %0d/%0d/%0d",
               seen, r.score, r.c1, r.c2, e.score, e.c1, e.c2);
    end
    $display("txn boundary score=%0d c1=%0d c2=%0d", r.score, r.c1, r.c2);
    accept();
  endtask

  task automatic test_done_in_load();
    bit seen; int cyc; res_t r, e;
    for (int i = 0; i < N; i++) begin
      px[i] = (i < 20) ? 1 : 10;
      py[i] = px[i];
    end
    c1x = 4'd1; c1y = 4'd1; c2x = 4'd1; c2y = 4'd1;
    load_points(20);
    total++;
    if (score_valid !== 1'b0) begin
      bad++;
      $display("FAIL done_in_load_early: got valid=%0b want 0", score_valid);
    end
    send_done(10, 10, 1, 14, 1'b1, model(10, 10, 1, 14));
    get_result(100, seen, cyc, r);
    e = exp_q.pop_front();
    total++;
    if (!seen || cyc != 41 || r !== e) begin
      bad++;
      $display("FAIL done_in_load: valid=%0b cyc=%0d got score=%0d c1=%0d c2=%0d want %0d/%0d/%0d",
               seen, cyc, r.score, r.c1, r.c2, e.score, e.c1, e.c2);
    end
    $display("txn done_in_load score=%0d c1=%0d c2=%0d", r.score, r.c1, r.c2);
    accept();
  endtask

  task automatic test_backpressure();
    bit seen; int cyc; res_t r, e, r0;
    for (int i = 0; i < N; i++) begin px[i] = 3; py[i] = 3; end
    load_points(-1);
    send_done(3, 3, 15, 15, 1'b1, model(3, 3, 15, 15));
    get_result(100, seen, r0, r);
    e = exp_q.pop_front();
    total++;
    if (!seen || r !== e) begin
      bad++;
      $display("FAIL backpressure_first: valid=%0b got score=%0d c1=%0d c2=%0d want %0d/%0d/%0d",
               seen, r.score, r.c1, r.c2, e.score, e.c1, e.c2);
    end
    r0 = r;
    for (int k = 0; k < 10; k++) begin
      pt_valid = k[0];
      x = 4'd0; y = 4'd0;
      tick();
      total++;
      if (score_valid !== 1'b1 || {score, c1_cnt, c2_cnt} !== r0) begin
        bad++;
        $display("FAIL backpressure_hold[%0d]: got valid=%0b score=%0d c1=%0d c2=%0d want 1 %0d/%0d/%0d",
                 k, score_valid, score, c1_cnt, c2_cnt, r0.score, r0.c1, r0.c2);
      end
    end
    pt_valid = 1'b1;
    score_ready = 1'b1;
    tick();
    pt_valid = 1'b0;
    score_ready = 1'b0;
    total++;
    if (score_valid !== 1'b0) begin
      bad++;
      $display("FAIL backpressure_drop: got valid=%0b want 0", score_valid);
    end
    $display("txn backpressure score=%0d c1=%0d c2=%0d", r0.score, r0.c1, r0.c2);
    for (int i = 0; i < N; i++) begin px[i] = 8; py[i] = 8; end
    load_points(-1);
    send_done(8, 8, 8, 8, 1'b1, {6'd40, 6'd40, 6'd40});
    get_result(100, seen, cyc, r);
    e = exp_q.pop_front();
    total++;
    if (!seen || cyc != 41 || r !== e) begin
      bad++;
      $display("FAIL backpressure_reload: valid=%0b cyc=%0d got score=%0d c1=%0d c2=%0d want %0d/%0d/%0d",
               seen, cyc, r.score, r.c1, r.c2, e.score, e.c1, e.c2);
    end
    $display("txn backpressure_reload score=%0d c1=%0d c2=%0d", r.score, r.c1, r.c2);
    accept();
  endtask

  task automatic test_reset_mid_eval();
    bit seen; int cyc; res_t r, e;
    int ax, ay, bx, by;
    for (int i = 0; i < N; i++) begin px[i] = 7; py[i] = 7; end
    load_points(-1);
    send_done(7, 7, 7, 9, 1'b0, '0);
    repeat (15) tick();
    rst_n = 1'b0;
    #1;
    total++;
    if ({score_valid, score, c1_cnt, c2_cnt} !== 19'd0) begin
      bad++;
      $display("FAIL reset_mid_eval: got valid=%0b score=%0d c1=%0d c2=%0d want all 0",
               score_valid, score, c1_cnt, c2_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < N; i++) begin
      px[i] = int'($urandom_range(0, 15));
      py[i] = int'($urandom_range(0, 15));
    end
    ax = int'($urandom_range(0, 15)); ay = int'($urandom_range(0, 15));
    bx = int'($urandom_range(0, 15)); by = int'($urandom_range(0, 15));
    load_points(-1);
    send_done(ax, ay, bx, by, 1'b1, model(ax, ay, bx, by));
    get_result(100, seen, cyc, r);
    e = exp_q.pop_front();
    total++;
    if (!seen || r !== e) begin
      bad++;
      $display("FAIL reset_reload: valid=%0b got score=%0d c1=%0d c2=%0d want %0d/%0d/%0d",
               seen, r.score, r.c1, r.c2, e.score, e.c1, e.c2);
    end
    $display("txn reset_reload score=%0d c1=%0d c2=%0d", r.score, r.c1, r.c2);
    accept();
  endtask

  task automatic test_back_to_back();
    bit seen; int cyc; res_t r, e;
    int ax, ay, bx, by;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) begin
        px[i] = int'($urandom_range(0, 15));
        py[i] = int'($urandom_range(0, 15));
      end
      ax = int'($urandom_range(0, 15)); ay = int'($urandom_range(0, 15));
      bx = int'($urandom_range(0, 15)); by = int'($urandom_range(0, 15));
      load_points(-1);
      send_done(ax, ay, bx, by, 1'b1, model(ax, ay, bx, by));
      get_result(100, seen, cyc, r);
      e = exp_q.pop_front();
      total++;
      if (!seen || r !== e) begin
        bad++;
        $display("FAIL back_to_back[%0d]: valid=%0b got score=%0d c1=%0d c2=%0d want %0d/%0d/%0d",
                 t, seen, r.score, r.c1, r.c2, e.score, e.c1, e.c2);
      end
      $display("txn back_to_back[%0d] score=%0d c1=%0d c2=%0d", t, r.score, r.c1, r.c2);
      accept();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pt_valid = 1'b0;
    x = '0; y = '0;
    c1x = '0; c1y = '0; c2x = '0; c2y = '0;
    done = 1'b0;
    score_ready = 1'b0;
    test_reset();
    test_same_centre();
    test_two_clusters();
    test_boundary();
    test_done_in_load();
    test_backpressure();
    test_reset_mid_eval();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
